// File: rtl/hp_au_pkg.sv
// Package for the hybrid-precision arithmetic unit: op encodings, FSM states
// and a small digit-validity helper shared by the datapath.
package hp_au_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [1:0] OP_BIN_ADD = 2'b00;
   localparam logic [1:0] OP_BIN_SUB = 2'b01;
   localparam logic [1:0] OP_BCD_ADD = 2'b10;
   localparam logic [1:0] OP_BCD_SUB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A packed-BCD nibble above 9 is not a decimal digit.
   function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
      return d > 4'd9;
   endfunction

endpackage

// File: rtl/bcd_adder_core.sv
// One-digit BCD adder with decimal carry in/out.
// Ports: a_i, b_i (digits), cin (carry in) -> sum (digit), cout_bcd (decimal carry).
module bcd_adder_core (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout_bcd
);

   logic [4:0] raw;

   // Binary sum, then +6 correction when the digit overflows past 9.
   always_comb begin
      raw      = 5'(a_i) + 5'(b_i) + 5'(cin);
      cout_bcd = raw > 5'd9;
      sum      = cout_bcd ? 4'(raw[3:0] + 4'd6) : raw[3:0];
   end

endmodule

// File: rtl/hp_au_seq.sv
// Sequential hybrid-precision arithmetic unit: single-cycle binary add/sub over
// the full word, digit-serial packed-BCD add (one digit per cycle).
// Macro HP_AU_BCD_SUB_EN enables BCD subtract (sel=11) via tens complement;
// without it sel=11 returns zero in one cycle.
// Ports: clk, rst_n; in_valid/in_ready + a, b, sel (operand handshake);
//        out_valid/out_ready + result, cout, zero, bcd_err (result handshake); busy.
module hp_au_seq
   import hp_au_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic [1:0]            sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  zero,
   output logic                  bcd_err,
   output logic                  busy
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned IW = $clog2(DIGITS) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
   logic [1:0]     sel_q, sel_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           carry_q, carry_d, err_q, err_d;
   logic           cout_q, cout_d, zero_q, zero_d, bcd_err_q, bcd_err_d;
   logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

   logic [3:0]     a_dig, b_dig, b_core, dsum;
   logic           dcarry, is_sub;
   logic [W-1:0]   bin_b;
   logic [W:0]     bin_sum;

   // Select the current digit pair by index; no shifting of the operands.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            a_dig = a_q[4*i +: 4];
            b_dig = b_q[4*i +: 4];
         end
      end
   end

   // Nines-complement of B in front of the adder for BCD subtract.
   always_comb begin
`ifdef HP_AU_BCD_SUB_EN
      is_sub = (sel_q == OP_BCD_SUB);
      b_core = is_sub ? 4'(4'd9 - b_dig) : b_dig;
`else
      is_sub = 1'b0;
      b_core = b_dig;
`endif
   end

   bcd_adder_core u_core (
      .a_i      (a_dig),
      .b_i      (b_core),
      .cin      (carry_q),
      .sum      (dsum),
      .cout_bcd (dcarry)
   );

   // Binary path: subtract is A + ~B + 1; carry inverted to give borrow.
   always_comb begin
      bin_b   = sel_q[0] ? ~b_q : b_q;
      bin_sum = {1'b0, a_q} + {1'b0, bin_b} + (W+1)'(sel_q[0]);
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sel_d     = sel_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      err_d     = err_q;
      acc_d     = acc_q;
      result_d  = result_q;
      cout_d    = cout_q;
      zero_d    = zero_q;
      bcd_err_d = bcd_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sel_d   = sel;
               idx_d   = '0;
               err_d   = 1'b0;
               acc_d   = '0;
`ifdef HP_AU_BCD_SUB_EN
               carry_d = (sel == OP_BCD_SUB);
`else
               carry_d = 1'b0;
`endif
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!sel_q[1]) begin
               result_d  = bin_sum[W-1:0];
               cout_d    = sel_q[0] ? ~bin_sum[W] : bin_sum[W];
               zero_d    = (bin_sum[W-1:0] == '0);
               bcd_err_d = 1'b0;
               state_d   = ST_DONE;
            end
`ifndef HP_AU_BCD_SUB_EN
            else if (sel_q[0]) begin
               result_d  = '0;
               cout_d    = 1'b0;
               zero_d    = 1'b1;
               bcd_err_d = 1'b0;
               state_d   = ST_DONE;
            end
`endif
            else begin
               err_d   = err_q | digit_bad(a_dig) | digit_bad(b_dig);
               carry_d = dcarry;
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx_q == IW'(i)) acc_d[4*i +: 4] = dsum;
               end
               if (idx_q == LAST_IDX) begin
                  result_d  = acc_d;
                  cout_d    = is_sub ? ~dcarry : dcarry;
                  zero_d    = (acc_d == '0);
                  bcd_err_d = err_d;
                  state_d   = ST_DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
         acc_q       <= '0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         bcd_err_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         zero_q      <= zero_d;
         bcd_err_q   <= bcd_err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign zero      = zero_q;
   assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_hp_au_seq.sv
// Testbench for hp_au_seq (DIGITS=4): directed and random ops against a
// decimal/integer reference model, backpressure and mid-operation reset.
module tb_hp_au_seq;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [1:0]    sel = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          cout, zero, bcd_err, busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   hp_au_seq #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .zero      (zero),
      .bcd_err   (bcd_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: binary as integer arithmetic; valid BCD as decimal numbers.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] ms, output logic [W-1:0] r,
                                 output logic c, output logic z, output logic e,
                                 output int lat);
      int da, db, v, s, cy, ad, bd;
      logic sub;
      r = '0; c = 1'b0; e = 1'b0; lat = 1;
      if (ms == 2'b00) begin
         v = int'(ma) + int'(mb);
         r = W'(v % 65536);
         c = (v >= 65536);
      end else if (ms == 2'b01) begin
         r = W'((int'(ma) - int'(mb) + 65536) % 65536);
         c = (ma < mb);
      end else begin
`ifndef HP_AU_BCD_SUB_EN
         if (ms == 2'b11) begin
            z = 1'b1;
            return;
         end
`endif
         sub = (ms == 2'b11);
         lat = DIGITS;
         da = 0; db = 0;
         for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) e = 1'b1;
            da = da * 10 + int'(ma[4*i +: 4]);
            db = db * 10 + int'(mb[4*i +: 4]);
         end
         if (!e) begin
            if (!sub) begin
               v = da + db;
               c = (v >= 10000);
               v = v % 10000;
            end else begin
               c = (da < db);
               v = c ? 10000 - (db - da) : da - db;
            end
            for (int i = 0; i < DIGITS; i++) begin
               r[4*i +: 4] = 4'(v % 10);
               v = v / 10;
            end
         end else begin
            // Non-decimal digits: follow the digit rule literally.
            cy = sub ? 1 : 0;
            for (int i = 0; i < DIGITS; i++) begin
               ad = int'(ma[4*i +: 4]);
               bd = sub ? int'(4'(4'd9 - mb[4*i +: 4])) : int'(mb[4*i +: 4]);
               s  = ad + bd + cy;
               if (s > 9) begin s = s + 6; cy = 1; end
               else cy = 0;
               r[4*i +: 4] = 4'(s % 16);
            end
            c = sub ? (cy == 0) : (cy == 1);
         end
      end
      z = (r == '0);
   endfunction

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] ts,
                        input int hold);
      logic [W-1:0] er;
      logic ec, ez, ee;
      int elat, lat, n;
      model(ta, tb, ts, er, ec, ez, ee, elat);
      @(negedge clk);
      in_valid = 1'b1; a = ta; b = tb; sel = ts;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check("in_ready_idle", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); sel = 2'($urandom);
      check("busy_exec", busy, 1);
      lat = 0;
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      check("latency", lat, elat);
      check("result", result, er);
      check("cout", cout, ec);
      check("zero", zero, ez);
      check("bcd_err", bcd_err, ee);
      check("in_ready_done", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom); sel = 2'($urandom);
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_result", result, er);
         check("hold_flags", {cout, zero, bcd_err}, {ec, ez, ee});
         check("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_result_held", result, er);
   endtask

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < DIGITS; i++)
         v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rs;
      logic       seen;
      #12;
      check("rst_result", result, 0);
      check("rst_flags", {cout, zero, bcd_err}, 3'b000);
      check("rst_valid_busy", {out_valid, busy}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      do_op(16'hFFFF, 16'h0001, 2'b00, 0);
      do_op(16'h0003, 16'h0005, 2'b01, 0);
      do_op(16'h0005, 16'h0003, 2'b01, 0);
      do_op(16'h9999, 16'h0001, 2'b10, 0);
      do_op(16'h00A0, 16'h0001, 2'b10, 0);
      do_op(16'h0100, 16'h0001, 2'b11, 0);
      do_op(16'h0001, 16'h0002, 2'b11, 0);
      do_op(16'h4321, 16'h1234, 2'b10, 5);

      for (int k = 0; k < 40; k++) begin
         rs = 2'($urandom);
         if (rs[1]) do_op(rand_bcd(), rand_bcd(), rs, int'($urandom_range(0, 2)));
         else       do_op(W'($urandom), W'($urandom), rs, int'($urandom_range(0, 2)));
      end

      // Nonzero result before the abort so the cleared outputs mean something.
      do_op(16'h1234, 16'h1111, 2'b00, 0);
      @(negedge clk);
      in_valid = 1'b1; a = 16'h1234; b = 16'h5678; sel = 2'b10;
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_result", result, 0);
      check("abort_flags", {cout, zero, bcd_err}, 3'b000);
      check("abort_valid_busy", {out_valid, busy}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      check("abort_no_valid", seen, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
